// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the CPU, the DMA engine, the arbiter and the SDRAM controller.
// The arbiter connects through the slave view; the surrounding system drives the master view.
interface sdram_arbiter_if;
    logic        cpu_rd_req;
    logic        cpu_wr_req;
    logic [21:0] cpu_addr;
    logic [15:0] cpu_wr_data;
    logic [15:0] cpu_rd_data;
    logic        cpu_wait_n;
    logic        dma_rd_req;
    logic        dma_wr_req;
    logic [21:0] dma_addr;
    logic [15:0] dma_wr_data;
    logic [15:0] dma_rd_data;
    logic        dma_ack;
    logic        ram_rd_req;
    logic        ram_wr_req;
    logic [21:0] ram_addr;
    logic [15:0] ram_wr_data;
    logic        ram_ready;
    logic [15:0] ram_rd_data;
    logic        busy;

    modport slave (
        input  cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wr_data,
        input  dma_rd_req, dma_wr_req, dma_addr, dma_wr_data,
        input  ram_ready, ram_rd_data,
        output cpu_rd_data, cpu_wait_n, dma_rd_data, dma_ack,
        output ram_rd_req, ram_wr_req, ram_addr, ram_wr_data, busy
    );

    modport master (
        output cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wr_data,
        output dma_rd_req, dma_wr_req, dma_addr, dma_wr_data,
        output ram_ready, ram_rd_data,
        input  cpu_rd_data, cpu_wait_n, dma_rd_data, dma_ack,
        input  ram_rd_req, ram_wr_req, ram_addr, ram_wr_data, busy
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares the single SDRAM controller port between the T80 CPU (fixed priority)
// and the DMA engine, forcing one DMA grant after STARVE_LIMIT CPU grants.
module sdram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clock_sys,
    input  logic           RESET_n,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_DMA_ACC = 2'd2
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic        served_q, served_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic        ram_rd_q, ram_rd_d;
    logic        ram_wr_q, ram_wr_d;
    logic [21:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;
    logic        dma_ack_q, dma_ack_d;
    logic        busy_q, busy_d;
    logic        cpu_any_s, cpu_pend_s, dma_pend_s, starve_s, cpu_done_s;

    // State and datapath registers
    always_ff @(posedge clock_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            served_q    <= 1'b0;
            run_cnt_q   <= 4'd0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= 22'd0;
            ram_wdata_q <= 16'd0;
            cpu_rdata_q <= 16'd0;
            dma_rdata_q <= 16'd0;
            dma_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            served_q    <= served_d;
            run_cnt_q   <= run_cnt_d;
            ram_rd_q    <= ram_rd_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            dma_ack_q   <= dma_ack_d;
            busy_q      <= busy_d;
        end
    end

    // Grant decision, access tracking and completion handling
    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        ram_rd_d    = ram_rd_q;
        ram_wr_d    = ram_wr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        dma_ack_d   = 1'b0;
        cpu_done_s  = 1'b0;

        cpu_any_s  = bus.cpu_rd_req | bus.cpu_wr_req;
        cpu_pend_s = cpu_any_s & ~served_q;
        dma_pend_s = bus.dma_rd_req | bus.dma_wr_req;
        starve_s   = dma_pend_s & (LIMIT != 4'd0) & (run_cnt_q >= LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (cpu_pend_s && !starve_s) begin
                    state_d     = ST_CPU_ACC;
                    ram_addr_d  = bus.cpu_addr;
                    ram_wdata_d = bus.cpu_wr_data;
                    ram_rd_d    = bus.cpu_rd_req;
                    ram_wr_d    = ~bus.cpu_rd_req;
                    // Counts only CPU wins that actually made DMA wait
                    if (!dma_pend_s) begin
                        run_cnt_d = 4'd0;
                    end else if (run_cnt_q != 4'd15) begin
                        run_cnt_d = run_cnt_q + 4'd1;
                    end else begin
                        run_cnt_d = run_cnt_q;
                    end
                end else if (dma_pend_s) begin
                    state_d     = ST_DMA_ACC;
                    ram_addr_d  = bus.dma_addr;
                    ram_wdata_d = bus.dma_wr_data;
                    ram_rd_d    = bus.dma_rd_req;
                    ram_wr_d    = ~bus.dma_rd_req;
                    run_cnt_d   = 4'd0;
                end else begin
                    state_d   = ST_IDLE;
                    run_cnt_d = 4'd0;
                end
            end
            ST_CPU_ACC: begin
                if (bus.ram_ready) begin
                    state_d    = ST_IDLE;
                    ram_rd_d   = 1'b0;
                    ram_wr_d   = 1'b0;
                    cpu_done_s = 1'b1;
                    if (ram_rd_q) begin
                        cpu_rdata_d = bus.ram_rd_data;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end else begin
                    state_d = ST_CPU_ACC;
                end
            end
            ST_DMA_ACC: begin
                if (bus.ram_ready) begin
                    state_d   = ST_IDLE;
                    ram_rd_d  = 1'b0;
                    ram_wr_d  = 1'b0;
                    dma_ack_d = 1'b1;
                    if (ram_rd_q) begin
                        dma_rdata_d = bus.ram_rd_data;
                    end else begin
                        dma_rdata_d = dma_rdata_q;
                    end
                end else begin
                    state_d = ST_DMA_ACC;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ram_rd_d = 1'b0;
                ram_wr_d = 1'b0;
            end
        endcase

        // A request already released by the Z80 leaves nothing to block
        served_d = cpu_any_s & (served_q | cpu_done_s);
        busy_d   = (state_d != ST_IDLE);
    end

    assign bus.cpu_rd_data = cpu_rdata_q;
    assign bus.cpu_wait_n  = ~cpu_pend_s;
    assign bus.dma_rd_data = dma_rdata_q;
    assign bus.dma_ack     = dma_ack_q;
    assign bus.ram_rd_req  = ram_rd_q;
    assign bus.ram_wr_req  = ram_wr_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wr_data = ram_wdata_q;
    assign bus.busy        = busy_q;
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter sharing the single SDRAM controller port (ram_rd_req / ram_wr_req / ram_ready) between the T80 CPU and a DMA requester (fast .TAP loader / save engine). The CPU has fixed priority, with a bounded-starvation guarantee for DMA. The arbiter stretches the CPU bus cycle through a wait output and serialises DMA transfers with a request/ack handshake. It sits between the ULA system section and the SDRAM controller, in the clock_sys domain.

## Interface
- STARVE_LIMIT, 4: consecutive CPU grants allowed while DMA is pending before one DMA grant is forced; 0 = pure CPU priority; legal range 0..15.
- clock_sys  in  1  system clock (~55 MHz); all logic on its rising edge.
- RESET_n  in  1  reset, asynchronous, active-low.
- cpu_rd_req / cpu_wr_req  in  1  CPU access request levels, held for the whole Z80 bus cycle.
- cpu_addr  in  22  CPU word address.
- cpu_wr_data  in  16  CPU write data.
- cpu_rd_data  out  16  last CPU read result, registered; reset 0.
- cpu_wait_n  out  1  to Z80 WAIT_n; low while a CPU request is pending and unserved.
- dma_rd_req / dma_wr_req  in  1  DMA request levels, held until dma_ack.
- dma_addr  in  22  DMA word address.
- dma_wr_data  in  16  DMA write data.
- dma_rd_data  out  16  last DMA read result, registered; reset 0.
- dma_ack  out  1  one-cycle completion strobe; reset 0.
- ram_rd_req / ram_wr_req  out  1  to SDRAM controller; reset 0.
- ram_addr  out  22  reset 0.
- ram_wr_data  out  16  reset 0.
- ram_ready  in  1  controller completion strobe; one cycle high per access; ram_rd_data valid in that cycle.
- ram_rd_data  in  16  controller read data.
- busy  out  1  high in the CPU_ACC and DMA_ACC states; reset 0.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - CPU_ACC: CPU access in progress.
  - DMA_ACC: DMA access in progress.
- Pending conditions:
  - cpu_pend = (cpu_rd_req | cpu_wr_req) & ~cpu_served.
  - dma_pend = dma_rd_req | dma_wr_req.
- IDLE grant decision:
  - If cpu_pend, and not (dma_pend & STARVE_LIMIT≠0 & run_cnt ≥ STARVE_LIMIT): go to CPU_ACC.
  - Else if dma_pend: go to DMA_ACC.
  - Else stay in IDLE.
- On grant, register into ram_addr / ram_wr_data / ram_rd_req / ram_wr_req:
  - The granted requester's address and write data.
  - Direction: read if that requester's rd_req is high, else write. rd_req and wr_req both high means read.
  - Later changes to requester inputs are ignored until the access completes.
- CPU_ACC, on ram_ready:
  - Clear ram_*_req.
  - Read: latch ram_rd_data into cpu_rd_data.
  - Set cpu_served.
  - Return to IDLE.
- DMA_ACC, on ram_ready:
  - Clear ram_*_req.
  - Read: latch ram_rd_data into dma_rd_data.
  - Pulse dma_ack.
  - Return to IDLE.
- cpu_served:
  - Cleared when cpu_rd_req and cpu_wr_req are both low.
  - Prevents re-issuing an access while the Z80 still holds MREQ/RD after completion.
- cpu_wait_n = ~cpu_pend, combinational from the inputs and the registered cpu_served.
- run_cnt (4 bits, saturating at 15):
  - Increments on each CPU grant made while dma_pend.
  - Clears on each DMA grant.
  - Clears in any IDLE cycle with dma_pend low.
- DMA must drop or change its request in the cycle after dma_ack. A request still held is treated as a new transfer.

## Timing
- Request present in IDLE at edge N: ram_*_req high from cycle N+1.
- ram_ready at cycle M:
  - ram_*_req low at M+1.
  - cpu_rd_data / dma_rd_data valid at M+1.
  - dma_ack high at M+1 only.
  - cpu_wait_n high at M+1.
  - FSM in IDLE at M+1.
- Next grant at the earliest on edge M+1, with ram_*_req high at M+2. This gives a minimum one-cycle gap between accesses.
- ram_ready outside CPU_ACC/DMA_ACC is ignored.
- Async reset mid-access:
  - All registers return to reset values immediately; the FSM goes to IDLE and cpu_served to 0.
  - The interrupted access is abandoned with no ack.
  - A still-held CPU request is re-issued after reset release.

## Test plan
- CPU read:
  - Stimulus: cpu_rd_req high at cycle 0, cpu_addr=0x004000; ram_ready at cycle 3 with ram_rd_data=0x00A5.
  - Required: ram_rd_req high cycles 1–3; ram_addr=0x004000; cpu_wait_n low cycles 0–3, high from 4; cpu_rd_data=0x00A5.
  - Then hold cpu_rd_req 10 more cycles: no new ram_rd_req.
- DMA write:
  - Stimulus: dma_wr_req, dma_addr=0x010000, dma_wr_data=0x1234; ram_ready at cycle 5.
  - Required: ram_wr_req high cycles 1–5 with that address and data; dma_ack exactly one cycle at 6.
- Simultaneous requests:
  - Stimulus: CPU write and DMA read both arrive at cycle 0.
  - Required: CPU is served first; ram_*_req low for one cycle; then the DMA access; each is acked once.
- Starvation, STARVE_LIMIT=2:
  - Stimulus: DMA held pending; CPU issues back-to-back requests.
  - Required: grant order CPU, CPU, DMA, CPU, CPU, DMA.
  - With STARVE_LIMIT=0: DMA is granted only when no CPU request is pending.
- Reset during access:
  - Stimulus: RESET_n low at the cycle after the CPU_ACC grant.
  - Required: ram_rd_req drops asynchronously; all outputs at reset values.
  - After release with the request still held: the access is re-issued and completes normally.
- Both directions requested:
  - Stimulus: cpu_rd_req and cpu_wr_req both high.
  - Required: ram_rd_req is asserted, ram_wr_req stays low.
